// File: rtl/pu_rf_pkg.sv
// Shared definitions for the PU register-file write-port controller:
// write-source encoding, reserved-register mask and configuration defaults.
package pu_rf_pkg;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W   = 4;

    // Reserved base registers: 8..18 and 31.
    localparam logic [31:0] RESERVED_MASK = 32'h8007_FF00;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2,
        SRC_HOST = 2'd3
    } src_e;

    function automatic logic is_reserved(input logic [31:0] addr);
        return (addr < 32'd32) && RESERVED_MASK[addr[4:0]];
    endfunction

endpackage

// File: rtl/pu_rf_scoreboard.sv
// Per-register busy bits for outstanding loads, with two combinational
// check ports for the issue stage. A set and a clear on the same register
// in one cycle leave the bit set.
module pu_rf_scoreboard
    import pu_rf_pkg::*;
#(
    parameter int unsigned DEPTH_NBITS = 5
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   set,
    input  logic [DEPTH_NBITS-1:0] set_addr,
    input  logic                   clr,
    input  logic [DEPTH_NBITS-1:0] clr_addr,
    input  logic [DEPTH_NBITS-1:0] chk_addr0,
    input  logic [DEPTH_NBITS-1:0] chk_addr1,
    output logic                   chk_busy0,
    output logic                   chk_busy1
);

    localparam int unsigned DEPTH = 1 << DEPTH_NBITS;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Clear first so a same-register set overrides it.
    always_comb begin
        busy_nxt = busy;
        if (clr) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set) begin
            busy_nxt[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // No bypass: checks see the state before this cycle's updates.
    assign chk_busy0 = busy[chk_addr0];
    assign chk_busy1 = busy[chk_addr1];

endmodule

// File: rtl/pu_rf_wr_ctl.sv
// Register-file write-port controller: fixed-priority arbitration of ALU,
// load-return and host writes, load starvation relief, and load scoreboard.
// Optional reserved-register write protection: define PU_RF_WR_PROTECT_EN.
module pu_rf_wr_ctl
    import pu_rf_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH_NBITS = 5,
    parameter int unsigned STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   alu_wr_valid,
    input  logic [DEPTH_NBITS-1:0] alu_wr_addr,
    input  logic [WIDTH-1:0]       alu_wr_data,
    output logic                   alu_hold,

    input  logic                   ld_wr_valid,
    output logic                   ld_wr_ready,
    input  logic [DEPTH_NBITS-1:0] ld_wr_addr,
    input  logic [WIDTH-1:0]       ld_wr_data,

    input  logic                   host_wr_valid,
    output logic                   host_wr_ready,
    input  logic [DEPTH_NBITS-1:0] host_wr_addr,
    input  logic [WIDTH-1:0]       host_wr_data,

    input  logic                   ld_issue,
    input  logic [DEPTH_NBITS-1:0] ld_issue_addr,
    input  logic [DEPTH_NBITS-1:0] chk_addr0,
    input  logic [DEPTH_NBITS-1:0] chk_addr1,
    output logic                   chk_busy0,
    output logic                   chk_busy1,

    output logic                   rf_wr,
    output logic [DEPTH_NBITS-1:0] rf_waddr,
    output logic [WIDTH-1:0]       rf_din,
    output logic                   prot_err
);

    localparam logic [STARVE_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [STARVE_CNT_W-1:0] CNT_HOLD = STARVE_CNT_W'(STARVE_MAX);

    src_e                    gnt_src;
    logic [DEPTH_NBITS-1:0]  gnt_addr;
    logic [WIDTH-1:0]        gnt_data;
    logic                    ld_gnt;
    logic                    drop;
    logic                    wr_en;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_nxt;
    logic                    hold_nxt;

    assign ld_wr_ready   = ~alu_wr_valid;
    assign host_wr_ready = ~alu_wr_valid & ~ld_wr_valid;
    assign ld_gnt        = ld_wr_valid & ld_wr_ready;

    // Fixed priority: ALU, then load return, then host.
    always_comb begin
        gnt_src  = SRC_NONE;
        gnt_addr = '0;
        gnt_data = '0;
        if (alu_wr_valid) begin
            gnt_src  = SRC_ALU;
            gnt_addr = alu_wr_addr;
            gnt_data = alu_wr_data;
        end else if (ld_wr_valid) begin
            gnt_src  = SRC_LD;
            gnt_addr = ld_wr_addr;
            gnt_data = ld_wr_data;
        end else if (host_wr_valid) begin
            gnt_src  = SRC_HOST;
            gnt_addr = host_wr_addr;
            gnt_data = host_wr_data;
        end
    end

`ifdef PU_RF_WR_PROTECT_EN
    // Datapath writes to reserved registers are granted but never reach the file.
    assign drop = ((gnt_src == SRC_ALU) || (gnt_src == SRC_LD)) &&
                  is_reserved(32'(gnt_addr));
`else
    assign drop = 1'b0;
`endif

    assign wr_en = (gnt_src != SRC_NONE) && !drop;

    // Consecutive cycles a pending load return has lost to the ALU; saturates.
    always_comb begin
        starve_nxt = '0;
        if (ld_wr_valid && !ld_gnt) begin
            starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt
                                                 : starve_cnt + STARVE_CNT_W'(1);
        end
    end

    // Pulse only on the transition into the threshold, never while parked there.
    assign hold_nxt = (starve_nxt == CNT_HOLD) && (starve_cnt != CNT_HOLD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_wr      <= 1'b0;
            rf_waddr   <= '0;
            rf_din     <= '0;
            prot_err   <= 1'b0;
            alu_hold   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            rf_wr      <= wr_en;
            prot_err   <= drop;
            alu_hold   <= hold_nxt;
            starve_cnt <= starve_nxt;
            if (wr_en) begin
                rf_waddr <= gnt_addr;
                rf_din   <= gnt_data;
            end
        end
    end

    pu_rf_scoreboard #(
        .DEPTH_NBITS (DEPTH_NBITS)
    ) u_scoreboard (
        .clk       (clk),
        .rstn      (rstn),
        .set       (ld_issue),
        .set_addr  (ld_issue_addr),
        .clr       (ld_gnt),
        .clr_addr  (ld_wr_addr),
        .chk_addr0 (chk_addr0),
        .chk_addr1 (chk_addr1),
        .chk_busy0 (chk_busy0),
        .chk_busy1 (chk_busy1)
    );

endmodule

// File: tb/tb_pu_rf_wr_ctl.sv
// Self-checking bench for pu_rf_wr_ctl: directed scenarios followed by
// random protocol-following traffic, checked against a behavioural model.
module tb_pu_rf_wr_ctl;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned DEPTH_NBITS = 5;
    localparam int unsigned STARVE_MAX  = 4;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   alu_wr_valid;
    logic [DEPTH_NBITS-1:0] alu_wr_addr;
    logic [WIDTH-1:0]       alu_wr_data;
    logic                   alu_hold;
    logic                   ld_wr_valid;
    logic                   ld_wr_ready;
    logic [DEPTH_NBITS-1:0] ld_wr_addr;
    logic [WIDTH-1:0]       ld_wr_data;
    logic                   host_wr_valid;
    logic                   host_wr_ready;
    logic [DEPTH_NBITS-1:0] host_wr_addr;
    logic [WIDTH-1:0]       host_wr_data;
    logic                   ld_issue;
    logic [DEPTH_NBITS-1:0] ld_issue_addr;
    logic [DEPTH_NBITS-1:0] chk_addr0;
    logic [DEPTH_NBITS-1:0] chk_addr1;
    logic                   chk_busy0;
    logic                   chk_busy1;
    logic                   rf_wr;
    logic [DEPTH_NBITS-1:0] rf_waddr;
    logic [WIDTH-1:0]       rf_din;
    logic                   prot_err;

    always #5 clk = ~clk;

    pu_rf_wr_ctl #(
        .WIDTH       (WIDTH),
        .DEPTH_NBITS (DEPTH_NBITS),
        .STARVE_MAX  (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .alu_wr_valid  (alu_wr_valid),
        .alu_wr_addr   (alu_wr_addr),
        .alu_wr_data   (alu_wr_data),
        .alu_hold      (alu_hold),
        .ld_wr_valid   (ld_wr_valid),
        .ld_wr_ready   (ld_wr_ready),
        .ld_wr_addr    (ld_wr_addr),
        .ld_wr_data    (ld_wr_data),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .ld_issue      (ld_issue),
        .ld_issue_addr (ld_issue_addr),
        .chk_addr0     (chk_addr0),
        .chk_addr1     (chk_addr1),
        .chk_busy0     (chk_busy0),
        .chk_busy1     (chk_busy1),
        .rf_wr         (rf_wr),
        .rf_waddr      (rf_waddr),
        .rf_din        (rf_din),
        .prot_err      (prot_err)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit [31:0]        m_busy;
    logic             m_rf_wr;
    logic [4:0]       m_waddr;
    logic [31:0]      m_din;
    logic             m_hold;
    logic             m_perr;
    int               m_starve;
    bit               hold_seen;
    bit               ld_gnt_last;
    bit               host_gnt_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reserved(input int a);
        return (a >= 8 && a <= 18) || a == 31;
    endfunction

    task automatic model_reset();
        m_busy        = '0;
        m_rf_wr       = 1'b0;
        m_waddr       = '0;
        m_din         = '0;
        m_hold        = 1'b0;
        m_perr        = 1'b0;
        m_starve      = 0;
        hold_seen     = 1'b0;
        ld_gnt_last   = 1'b0;
        host_gnt_last = 1'b0;
    endtask

    task automatic idle_inputs();
        alu_wr_valid  = 1'b0; alu_wr_addr  = '0; alu_wr_data  = '0;
        ld_wr_valid   = 1'b0; ld_wr_addr   = '0; ld_wr_data   = '0;
        host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
        ld_issue      = 1'b0; ld_issue_addr = '0;
        chk_addr0     = '0;   chk_addr1    = '0;
    endtask

    // Check all outputs mid-cycle, then advance the model over the clock edge.
    task automatic cycle();
        bit ag, lg, hg, drop;
        @(negedge clk);
        chk("ld_wr_ready",   64'(ld_wr_ready),   64'(!alu_wr_valid));
        chk("host_wr_ready", 64'(host_wr_ready), 64'(!alu_wr_valid && !ld_wr_valid));
        chk("chk_busy0",     64'(chk_busy0),     64'(m_busy[chk_addr0]));
        chk("chk_busy1",     64'(chk_busy1),     64'(m_busy[chk_addr1]));
        chk("rf_wr",         64'(rf_wr),         64'(m_rf_wr));
        chk("rf_waddr",      64'(rf_waddr),      64'(m_waddr));
        chk("rf_din",        64'(rf_din),        64'(m_din));
        chk("alu_hold",      64'(alu_hold),      64'(m_hold));
        chk("prot_err",      64'(prot_err),      64'(m_perr));

        ag = alu_wr_valid;
        lg = ld_wr_valid && !alu_wr_valid;
        hg = host_wr_valid && !alu_wr_valid && !ld_wr_valid;
`ifdef PU_RF_WR_PROTECT_EN
        drop = (ag && reserved(int'(alu_wr_addr))) || (lg && reserved(int'(ld_wr_addr)));
`else
        drop = 1'b0;
`endif
        if ((ag || lg || hg) && !drop) begin
            m_rf_wr = 1'b1;
            m_waddr = ag ? alu_wr_addr : (lg ? ld_wr_addr : host_wr_addr);
            m_din   = ag ? alu_wr_data : (lg ? ld_wr_data : host_wr_data);
        end else begin
            m_rf_wr = 1'b0;
        end
        m_perr    = drop;
        hold_seen = m_hold;
        if (ld_wr_valid && !lg) m_starve++;
        else                    m_starve = 0;
        m_hold = (m_starve == int'(STARVE_MAX));
        if (lg)       m_busy[ld_wr_addr] = 1'b0;
        if (ld_issue) m_busy[ld_issue_addr] = 1'b1;
        ld_gnt_last   = lg;
        host_gnt_last = hg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rstn = 1'b0;
        #12;
        chk("rst_rf_wr",     64'(rf_wr),         64'(0));
        chk("rst_rf_waddr",  64'(rf_waddr),      64'(0));
        chk("rst_rf_din",    64'(rf_din),        64'(0));
        chk("rst_alu_hold",  64'(alu_hold),      64'(0));
        chk("rst_prot_err",  64'(prot_err),      64'(0));
        chk("rst_ld_ready",  64'(ld_wr_ready),   64'(1));
        chk("rst_host_ready",64'(host_wr_ready), 64'(1));
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle();

        // All three requesters at once: ALU wins, then load, then host.
        alu_wr_valid  = 1'b1; alu_wr_addr  = 5'd3; alu_wr_data  = 32'hAAAA_0001;
        ld_wr_valid   = 1'b1; ld_wr_addr   = 5'd4; ld_wr_data   = 32'hBBBB_0002;
        host_wr_valid = 1'b1; host_wr_addr = 5'd5; host_wr_data = 32'hCCCC_0003;
        #1;
        chk("tri_ld_ready",   64'(ld_wr_ready),   64'(0));
        chk("tri_host_ready", 64'(host_wr_ready), 64'(0));
        cycle();
        chk("tri_waddr", 64'(rf_waddr), 64'(3));
        chk("tri_din",   64'(rf_din),   64'(32'hAAAA_0001));
        alu_wr_valid = 1'b0;
        cycle();
        chk("tri_ld_waddr", 64'(rf_waddr), 64'(4));
        ld_wr_valid = 1'b0;
        cycle();
        chk("tri_host_waddr", 64'(rf_waddr), 64'(5));
        chk("tri_host_din",   64'(rf_din),   64'(32'hCCCC_0003));
        host_wr_valid = 1'b0;
        cycle();
        chk("idle_rf_wr",    64'(rf_wr),    64'(0));
        chk("idle_hold_addr",64'(rf_waddr), 64'(5));

        // Starvation: load to r7 loses to the ALU for STARVE_MAX cycles.
        ld_wr_valid = 1'b1; ld_wr_addr = 5'd7; ld_wr_data = 32'hDDDD_0007;
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd1;
        for (int i = 0; i < int'(STARVE_MAX); i++) begin
            alu_wr_data = 32'h100 + 32'(i);
            cycle();
        end
        chk("starve_hold_on", 64'(alu_hold), 64'(1));
        alu_wr_data = 32'h1FF;
        cycle();
        chk("starve_hold_off", 64'(alu_hold), 64'(0));
        alu_wr_valid = 1'b0;
        cycle();
        chk("starve_ld_wr",    64'(rf_wr),    64'(1));
        chk("starve_ld_waddr", 64'(rf_waddr), 64'(7));
        chk("starve_ld_din",   64'(rf_din),   64'(32'hDDDD_0007));
        ld_wr_valid = 1'b0;
        // Counter must have cleared: three more losses do not raise hold.
        ld_wr_valid = 1'b1; ld_wr_addr = 5'd20; alu_wr_valid = 1'b1;
        for (int i = 0; i < int'(STARVE_MAX) - 1; i++) cycle();
        chk("starve_cleared", 64'(alu_hold), 64'(0));
        alu_wr_valid = 1'b0;
        cycle();
        ld_wr_valid = 1'b0;
        cycle();

        // Scoreboard set by issue, cleared by the load return.
        ld_issue = 1'b1; ld_issue_addr = 5'd12;
        cycle();
        ld_issue = 1'b0; chk_addr0 = 5'd12;
        #1;
        chk("sb_busy12", 64'(chk_busy0), 64'(1));
        ld_wr_valid = 1'b1; ld_wr_addr = 5'd12; ld_wr_data = 32'h1212_1212;
        #1;
        chk("sb_no_bypass", 64'(chk_busy0), 64'(1));
        cycle();
        ld_wr_valid = 1'b0;
        #1;
        chk("sb_cleared12", 64'(chk_busy0), 64'(0));
        cycle();

        // Same-cycle set and clear on r6: set wins.
        ld_issue = 1'b1; ld_issue_addr = 5'd6;
        cycle();
        ld_wr_valid = 1'b1; ld_wr_addr = 5'd6; ld_wr_data = 32'h0606_0606;
        cycle();
        ld_issue = 1'b0; ld_wr_valid = 1'b0; chk_addr1 = 5'd6;
        #1;
        chk("sb_set_wins", 64'(chk_busy1), 64'(1));
        cycle();

        // Reserved register r9: ALU write vs host write.
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd9; alu_wr_data = 32'h9999_0001;
        cycle();
        alu_wr_valid = 1'b0;
`ifdef PU_RF_WR_PROTECT_EN
        chk("prot_alu_rf_wr", 64'(rf_wr),    64'(0));
        chk("prot_alu_err",   64'(prot_err), 64'(1));
`else
        chk("prot_alu_rf_wr", 64'(rf_wr),    64'(1));
        chk("prot_alu_err",   64'(prot_err), 64'(0));
`endif
        host_wr_valid = 1'b1; host_wr_addr = 5'd9; host_wr_data = 32'h9999_0002;
        cycle();
        host_wr_valid = 1'b0;
        chk("prot_host_rf_wr", 64'(rf_wr),    64'(1));
        chk("prot_host_err",   64'(prot_err), 64'(0));
        cycle();

        // Asynchronous reset with a pending load and r2 busy.
        ld_issue = 1'b1; ld_issue_addr = 5'd2;
        cycle();
        ld_issue = 1'b0;
        alu_wr_valid = 1'b1; alu_wr_addr = 5'd1; alu_wr_data = 32'h0000_00A1;
        ld_wr_valid = 1'b1; ld_wr_addr = 5'd2; ld_wr_data = 32'h0000_0002;
        chk_addr0 = 5'd2;
        cycle();
        chk("prerst_busy2", 64'(chk_busy0), 64'(1));
        chk("prerst_rf_wr", 64'(rf_wr),     64'(1));
        #2;
        rstn = 1'b0;
        alu_wr_valid = 1'b0; ld_wr_valid = 1'b0;
        #1;
        chk("arst_rf_wr",    64'(rf_wr),     64'(0));
        chk("arst_rf_waddr", 64'(rf_waddr),  64'(0));
        chk("arst_rf_din",   64'(rf_din),    64'(0));
        chk("arst_hold",     64'(alu_hold),  64'(0));
        chk("arst_prot_err", 64'(prot_err),  64'(0));
        chk("arst_busy2",    64'(chk_busy0), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        model_reset();
        #1;
        chk("postrst_busy2", 64'(chk_busy0), 64'(0));
        cycle();

        // Random traffic obeying the valid/ready and hold protocols.
        for (int n = 0; n < 600; n++) begin
            alu_wr_valid = hold_seen ? 1'b0 : ($urandom_range(0, 9) < 6);
            alu_wr_addr  = 5'($urandom);
            alu_wr_data  = $urandom;
            if (!(ld_wr_valid && !ld_gnt_last)) begin
                ld_wr_valid = ($urandom_range(0, 1) == 1);
                ld_wr_addr  = 5'($urandom);
                ld_wr_data  = $urandom;
            end
            if (!(host_wr_valid && !host_gnt_last)) begin
                host_wr_valid = ($urandom_range(0, 3) == 0);
                host_wr_addr  = 5'($urandom);
                host_wr_data  = $urandom;
            end
            ld_issue      = ($urandom_range(0, 9) < 3);
            ld_issue_addr = 5'($urandom);
            chk_addr0     = 5'($urandom);
            chk_addr1     = 5'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pu_rf_wr_ctl.md
# pu_rf_wr_ctl

Write-port controller for the PU's 32-entry register file. It arbitrates the single register-file write port among three sources: ALU writeback, load return and host configuration. It also keeps a per-register scoreboard of outstanding loads so the issue stage can detect read-after-load hazards. It sits between the PU execute/memory stages and the register file, and drives the file's `wr`, `waddr` and `din` inputs from registered outputs.

## Interface
- `WIDTH`, 32, register data width
- `DEPTH_NBITS`, 5, register address width (DEPTH = 1<<DEPTH_NBITS)
- `STARVE_MAX`, 4, consecutive cycles a valid load return may lose to ALU before `alu_hold` asserts (range 1..15)

Ports:
- `clk` in 1 — single clock
- `rstn` in 1 — reset, asynchronous, active-low
- `alu_wr_valid` in 1 — ALU writeback request; always granted, no ready
- `alu_wr_addr` in DEPTH_NBITS — ALU destination register
- `alu_wr_data` in WIDTH — ALU result
- `alu_hold` out 1 — tells execute not to present `alu_wr_valid` next cycle
- `ld_wr_valid` in 1 — load-return request
- `ld_wr_ready` out 1 — load-return grant
- `ld_wr_addr` in DEPTH_NBITS — load-return destination register
- `ld_wr_data` in WIDTH — load-return data
- `host_wr_valid` in 1 — host configuration write request
- `host_wr_ready` out 1 — host write grant
- `host_wr_addr` in DEPTH_NBITS — host destination register
- `host_wr_data` in WIDTH — host write data
- `ld_issue` in 1 — a load has issued; mark its destination busy
- `ld_issue_addr` in DEPTH_NBITS — destination of the issued load
- `chk_addr0`, `chk_addr1` in DEPTH_NBITS — issue-stage source operands
- `chk_busy0`, `chk_busy1` out 1 — scoreboard bit of each source (combinational)
- `rf_wr` out 1 — register-file write enable (registered)
- `rf_waddr` out DEPTH_NBITS — register-file write address (registered)
- `rf_din` out WIDTH — register-file write data (registered)
- `prot_err` out 1 — one-cycle pulse when a protected write is dropped (only with PU_RF_WR_PROTECT_EN)

## Operation
- Fixed priority: ALU, then load, then host.
  - `ld_wr_ready = ~alu_wr_valid`
  - `host_wr_ready = ~alu_wr_valid & ~ld_wr_valid`
- Ready signals are combinational from the valids.
- A transfer occurs when valid & ready are both high.
- Once a requester raises valid, it holds valid, address and data stable until ready.
- Starvation counter (4 bits):
  - increments each cycle `ld_wr_valid & alu_wr_valid`
  - clears on a load grant or when `ld_wr_valid` is low
  - when the count reaches `STARVE_MAX`, `alu_hold` is high for exactly one cycle
  - execute keeps `alu_wr_valid` low in the following cycle, which lets the load win
  - a held-off ALU result is execute's responsibility
- Scoreboard: one busy bit per register.
  - `ld_issue` sets `busy[ld_issue_addr]`.
  - A granted load return clears `busy[ld_wr_addr]`.
  - If set and clear hit the same address in the same cycle, set wins.
  - ALU and host writes do not touch the scoreboard.
- `chk_busy*` reflects the current busy bits. It does not bypass a clear happening this cycle.
- Reset:
  - all busy bits 0, starvation counter 0
  - `rf_wr`, `rf_waddr`, `rf_din`, `alu_hold`, `prot_err` all 0
  - ready outputs follow the valids (inputs assumed low during reset)
- Reset mid-operation: in-flight grants are lost and the scoreboard clears. The register file reloads its own reset values.

## Timing
- Grant in cycle N gives `rf_wr`/`rf_waddr`/`rf_din` valid in cycle N+1. The register file captures the write at the end of N+1.
- No grant in cycle N gives `rf_wr = 0` in N+1. `rf_waddr`/`rf_din` hold their previous values.
- Scoreboard updates take effect at the clock edge after `ld_issue` or the load grant.
- `alu_hold` is asserted in the cycle after the counter reaches `STARVE_MAX`, and lasts one cycle.
- Throughput: one write per cycle.

## Configuration
- `PU_RF_WR_PROTECT_EN` defined:
  - ALU and load-return writes to reserved base registers (8–18, 31) are still granted and still clear the scoreboard.
  - `rf_wr` stays 0 for that grant, and `prot_err` pulses in cycle N+1.
  - Host writes are never blocked.
- `PU_RF_WR_PROTECT_EN` undefined:
  - all granted writes reach the register file
  - `prot_err` is tied to 0

## Structure
- Shared package `pu_rf_pkg` holds:
  - a source enum (`SRC_ALU`, `SRC_LD`, `SRC_HOST`)
  - the reserved-register mask constant (bits 8–18, 31)
  - a default for `STARVE_MAX`
- One sub-module, `pu_rf_scoreboard`: busy-bit array, set/clear logic, two combinational check ports.
- Arbiter, starvation counter and output register stay in the top level.

## Test plan
- ALU, load and host all valid on the same cycle, with addrs 3/4/5 and data A/B/C:
  - `rf_waddr=3`, `rf_din=A` next cycle
  - `ld_wr_ready=0`, `host_wr_ready=0`
- `ld_wr_valid` held while ALU is valid for 4 consecutive cycles (`STARVE_MAX=4`):
  - `alu_hold` pulses once
  - the load to reg 7 writes 2 cycles later
  - the counter returns to 0
- `ld_issue` on reg 12, then `chk_addr0=12`:
  - `chk_busy0=1`
  - the load return to 12 is granted, and `chk_busy0=0` the cycle after
- Same cycle `ld_issue` on reg 6 and a granted load return to reg 6:
  - `busy[6]` stays 1
- With `PU_RF_WR_PROTECT_EN`:
  - ALU write to reg 9 gives `rf_wr=0` and a `prot_err` pulse
  - host write to reg 9 gives `rf_wr=1`
- `rstn` pulled low while a load is pending and `busy[2]=1`:
  - all outputs go to 0 asynchronously
  - `busy[2]=0` after reset release
